// File: rtl/complex_fix_div.sv
// Complex fixed-point divider: out = x*conj(y)/|y|^2, Q1.18 in, Q2.18 out, saturating.
// Latency 44 cycles from accepted start to done; start ignored while busy (no queuing).
// Optional COMPLEX_FIX_DIV_ROUND_EN: round half away from zero instead of truncating.
module complex_fix_div (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic signed [18:0] x_re,
  input  logic signed [18:0] x_im,
  input  logic signed [18:0] y_re,
  input  logic signed [18:0] y_im,
  output logic signed [19:0] out_re,
  output logic signed [19:0] out_im,
  output logic               busy,
  output logic               done,
  output logic               ovf,
  output logic               div_zero
);

  typedef enum logic [2:0] {IDLE, SETUP, DIV_RE, DIV_IM, DONE} state_t;
  state_t state, state_nxt;

  logic signed [18:0] xr, xi, yr, yi;
  logic        [37:0] mag_re, mag_im, dd;
  logic               neg_re, neg_im, dz;
  logic        [36:0] rem;
  logic        [20:0] lo;
  logic        [19:0] q;
  logic        [4:0]  cnt;
  logic               big;
  logic        [19:0] re_val;
  logic               re_sat;

  // Full-width numerator/denominator from the captured operands.
  logic signed [38:0] xr_e, xi_e, yr_e, yi_e, nre_c, nim_c, d_c;
  logic        [38:0] are_c, aim_c;
  assign xr_e  = $signed({{20{xr[18]}}, xr});
  assign xi_e  = $signed({{20{xi[18]}}, xi});
  assign yr_e  = $signed({{20{yr[18]}}, yr});
  assign yi_e  = $signed({{20{yi[18]}}, yi});
  assign nre_c = xr_e * yr_e + xi_e * yi_e;
  assign nim_c = xi_e * yr_e - xr_e * yi_e;
  assign d_c   = yr_e * yr_e + yi_e * yi_e;
  assign are_c = nre_c[38] ? 39'(-nre_c) : nre_c;
  assign aim_c = nim_c[38] ? 39'(-nim_c) : nim_c;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  logic [37:0] trial;
  logic        ge;
  logic [36:0] rem_n;
  logic [20:0] q_n;
  logic        rnd;
  assign trial = {rem, lo[20]};
  assign ge    = (trial >= dd);
  assign rem_n = ge ? 37'(trial - dd) : trial[36:0];
  assign q_n   = {q, ge};
`ifdef COMPLEX_FIX_DIV_ROUND_EN
  assign rnd   = ({rem_n, 1'b0} >= dd);
`else
  assign rnd   = 1'b0;
`endif

  // Returns {saturated, value}; big means the quotient already exceeded 21 bits.
  function automatic logic [20:0] finish(input logic neg, input logic ovr,
                                         input logic [20:0] qv, input logic up);
    logic [21:0] mag;
    logic        sat;
    logic [19:0] val;
    mag = {1'b0, qv} + {21'd0, up};
    sat = ovr || (neg ? (mag > 22'd524288) : (mag > 22'd524287));
    if (sat)
      val = neg ? 20'h80000 : 20'h7FFFF;
    else
      val = neg ? 20'(-mag[19:0]) : mag[19:0];
    return {sat, val};
  endfunction

  logic [20:0] fin;
  assign fin = finish((state == DIV_RE) ? neg_re : neg_im, big, q_n, rnd);

  // Load the divider with |N|>>3; if that already reaches D the quotient cannot fit.
  function automatic logic [59:0] load(input logic [37:0] m, input logic [37:0] d);
    logic ovr;
    ovr = ({3'b000, m[37:3]} >= d);
    return {ovr, {2'b00, m[37:3]}, m[2:0], 18'd0};
  endfunction

  logic [59:0] ld;
  assign ld = load((state == DIV_RE && cnt == 5'd0) ? mag_re : mag_im, dd);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETUP;
      SETUP:   state_nxt = DIV_RE;
      DIV_RE:  if (cnt == 5'd21) state_nxt = DIV_IM;
      DIV_IM:  if (cnt == 5'd21) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SETUP) || (state == DIV_RE) || (state == DIV_IM);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      xr <= '0; xi <= '0; yr <= '0; yi <= '0;
      mag_re <= '0; mag_im <= '0; dd <= '0;
      neg_re <= 1'b0; neg_im <= 1'b0; dz <= 1'b0;
      rem <= '0; lo <= '0; q <= '0; cnt <= '0; big <= 1'b0;
      re_val <= '0; re_sat <= 1'b0;
      out_re <= '0; out_im <= '0; ovf <= 1'b0; div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          xr <= x_re; xi <= x_im; yr <= y_re; yi <= y_im;
        end
        SETUP: begin
          mag_re <= are_c[37:0];
          mag_im <= aim_c[37:0];
          neg_re <= nre_c[38];
          neg_im <= nim_c[38];
          dd     <= d_c[37:0];
          dz     <= (d_c == '0);
          cnt    <= '0;
        end
        DIV_RE: begin
          if (cnt == 5'd0) begin
            {big, rem, lo} <= ld;
            q   <= '0;
            cnt <= 5'd1;
          end else if (cnt == 5'd21) begin
            re_sat <= fin[20];
            re_val <= fin[19:0];
            {big, rem, lo} <= ld;
            q   <= '0;
            cnt <= 5'd1;
          end else begin
            rem <= rem_n;
            lo  <= {lo[19:0], 1'b0};
            q   <= q_n[19:0];
            cnt <= cnt + 5'd1;
          end
        end
        DIV_IM: begin
          if (cnt == 5'd21) begin
            out_re   <= dz ? '0 : re_val;
            out_im   <= dz ? '0 : fin[19:0];
            ovf      <= ~dz & (re_sat | fin[20]);
            div_zero <= dz;
          end
          rem <= rem_n;
          lo  <= {lo[19:0], 1'b0};
          q   <= q_n[19:0];
          cnt <= cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
